// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the D-stage register-use info, the branch/memory status inputs and
//   the stall/flush/forward controls exchanged between the pipeline datapath
//   and hazard_ctrl.
//   master : pipeline side (drives D-stage info, pcsrc_e, dmem_ready)
//   slave  : hazard_ctrl side (drives stall/flush/forward selects)
//   Parameter REG_AW : register address width.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    // D-stage instruction info and pipeline status
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic [REG_AW-1:0] rd_d;
    logic              regwrite_d;
    logic              isload_d;
    logic              memacc_d;
    logic              valid_d;
    logic              pcsrc_e;
    logic              dmem_ready;
    // Pipeline-register controls
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              stall_e;
    logic              flush_e;
    logic              stall_m;
    logic              flush_w;
    logic [1:0]        forwardae;
    logic [1:0]        forwardbe;

    modport master (
        output rs1_d, rs2_d, rd_d, regwrite_d, isload_d, memacc_d, valid_d,
        output pcsrc_e, dmem_ready,
        input  stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w,
        input  forwardae, forwardbe
    );

    modport slave (
        input  rs1_d, rs2_d, rd_d, regwrite_d, isload_d, memacc_d, valid_d,
        input  pcsrc_e, dmem_ready,
        output stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w,
        output forwardae, forwardbe
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and sequencing controller for the 5-stage RV32I pipe (F/D/E/M/W).
//   Keeps a shadow copy of register-use info for E, M and W and produces the
//   stall / flush / forwarding selects for the pipeline registers:
//     - load-use stall (1 bubble)
//     - taken branch/jump flush (2 bubbles)
//     - whole-pipe freeze while the M-stage dmem access is not ready
//   Ports:
//     clk, rst_n : core clock, asynchronous active-low reset
//     hz         : hazard_ctrl_if.slave (D-stage info in, controls out)
//   Optional build macro HAZARD_PERF_CNT_EN adds wrapping perf counters
//     stall_cnt, flush_cnt, memwait_cnt [CNT_W-1:0].
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_ctrl: CNT_W must be at least 1");
    end

    // Shadow state
    logic [REG_AW-1:0] r_rs1_e, r_rs2_e, r_rd_e;
    logic              r_regwrite_e, r_isload_e, r_memacc_e, r_valid_e;
    logic [REG_AW-1:0] r_rd_m;
    logic              r_regwrite_m, r_memacc_m, r_valid_m;
    logic [REG_AW-1:0] r_rd_w;
    logic              r_regwrite_w, r_valid_w;

    logic w_mem_wait, w_lwstall, w_bubble_e;
    logic w_m_wr, w_w_wr;

    assign w_mem_wait = r_valid_m & r_memacc_m & ~hz.dmem_ready;
    assign w_lwstall  = r_valid_e & r_isload_e & (r_rd_e != '0) & hz.valid_d &
                        ((r_rd_e == hz.rs1_d) | (r_rd_e == hz.rs2_d));
    assign w_bubble_e = w_lwstall | hz.pcsrc_e;

    // A stage can forward only if it really writes a non-x0 register
    assign w_m_wr = r_valid_m & r_regwrite_m & (r_rd_m != '0);
    assign w_w_wr = r_valid_w & r_regwrite_w & (r_rd_w != '0);

    // M beats W: it holds the younger value of the register
    assign hz.forwardae = (w_m_wr && r_rd_m == r_rs1_e) ? 2'b10 :
                          (w_w_wr && r_rd_w == r_rs1_e) ? 2'b01 : 2'b00;
    assign hz.forwardbe = (w_m_wr && r_rd_m == r_rs2_e) ? 2'b10 :
                          (w_w_wr && r_rd_w == r_rs2_e) ? 2'b01 : 2'b00;

    always_comb begin
        hz.stall_f = 1'b0;
        hz.stall_d = 1'b0;
        hz.flush_d = 1'b0;
        hz.stall_e = 1'b0;
        hz.flush_e = 1'b0;
        hz.stall_m = 1'b0;
        hz.flush_w = 1'b0;
        if (w_mem_wait) begin
            // Freeze F..M; W takes a bubble. A pending branch in E is
            // re-presented once the access completes, so it is ignored here.
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
            hz.stall_e = 1'b1;
            hz.stall_m = 1'b1;
            hz.flush_w = 1'b1;
        end else begin
            hz.stall_f = w_lwstall;
            hz.stall_d = w_lwstall;
            hz.flush_d = hz.pcsrc_e;      // flush wins over stall for IF/ID
            hz.flush_e = w_bubble_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1_e      <= '0;
            r_rs2_e      <= '0;
            r_rd_e       <= '0;
            r_regwrite_e <= 1'b0;
            r_isload_e   <= 1'b0;
            r_memacc_e   <= 1'b0;
            r_valid_e    <= 1'b0;
            r_rd_m       <= '0;
            r_regwrite_m <= 1'b0;
            r_memacc_m   <= 1'b0;
            r_valid_m    <= 1'b0;
            r_rd_w       <= '0;
            r_regwrite_w <= 1'b0;
            r_valid_w    <= 1'b0;
        end else if (w_mem_wait) begin
            // E and M hold; W becomes a bubble
            r_rd_w       <= '0;
            r_regwrite_w <= 1'b0;
            r_valid_w    <= 1'b0;
        end else begin
            r_rd_w       <= r_rd_m;
            r_regwrite_w <= r_regwrite_m;
            r_valid_w    <= r_valid_m;
            r_rd_m       <= r_rd_e;
            r_regwrite_m <= r_regwrite_e;
            r_memacc_m   <= r_memacc_e;
            r_valid_m    <= r_valid_e;
            if (w_bubble_e) begin
                r_rs1_e      <= '0;
                r_rs2_e      <= '0;
                r_rd_e       <= '0;
                r_regwrite_e <= 1'b0;
                r_isload_e   <= 1'b0;
                r_memacc_e   <= 1'b0;
                r_valid_e    <= 1'b0;
            end else begin
                r_rs1_e      <= hz.rs1_d;
                r_rs2_e      <= hz.rs2_d;
                r_rd_e       <= hz.rd_d;
                r_regwrite_e <= hz.regwrite_d;
                r_isload_e   <= hz.isload_d;
                r_memacc_e   <= hz.memacc_d;
                r_valid_e    <= hz.valid_d;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else if (w_mem_wait) begin
            memwait_cnt <= memwait_cnt + 1'b1;
        end else begin
            if (w_lwstall)  stall_cnt <= stall_cnt + 1'b1;
            if (hz.pcsrc_e) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed, table-driven bench for hazard_ctrl. Each table record is one
//   clock cycle of D-stage inputs plus the expected combinational outputs;
//   the shadow pipeline carries over from record to record. Reset entry,
//   release and mid-operation reset are hand-written sequences.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5)) hif ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

    hazard_ctrl #(.REG_AW(5), .CNT_W(32)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hz          (hif)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .memwait_cnt (memwait_cnt)
`endif
    );

    typedef struct {
        logic       vd;
        logic [4:0] rs1, rs2, rd;
        logic       rw, ld, ma, pc, rdy;
        logic [6:0] ctrl;   // {stall_f,stall_d,flush_d,stall_e,flush_e,stall_m,flush_w}
        logic [1:0] fa, fb;
    } vec_t;

    localparam logic [6:0] C0    = 7'b0000000;
    localparam logic [6:0] CLU   = 7'b1100100;
    localparam logic [6:0] CBR   = 7'b0010100;
    localparam logic [6:0] CMW   = 7'b1101011;
    localparam logic [6:0] CBOTH = 7'b1110100;

    int   n_chk = 0;
    int   n_err = 0;
    vec_t tbl[$];

    function automatic vec_t v(input logic vd, input logic [4:0] rs1, rs2, rd,
                               input logic rw, ld, ma, pc, rdy,
                               input logic [6:0] ctrl, input logic [1:0] fa, fb);
        vec_t r;
        r.vd = vd; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.rw = rw; r.ld = ld; r.ma = ma; r.pc = pc; r.rdy = rdy;
        r.ctrl = ctrl; r.fa = fa; r.fb = fb;
        return r;
    endfunction

    function automatic vec_t nop(input logic [6:0] ctrl, input logic [1:0] fa, fb);
        return v(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ctrl, fa, fb);
    endfunction

    task automatic drive(input vec_t x);
        hif.valid_d    = x.vd;
        hif.rs1_d      = x.rs1;
        hif.rs2_d      = x.rs2;
        hif.rd_d       = x.rd;
        hif.regwrite_d = x.rw;
        hif.isload_d   = x.ld;
        hif.memacc_d   = x.ma;
        hif.pcsrc_e    = x.pc;
        hif.dmem_ready = x.rdy;
    endtask

    function automatic logic [10:0] outs();
        return {hif.stall_f, hif.stall_d, hif.flush_d, hif.stall_e, hif.flush_e,
                hif.stall_m, hif.flush_w, hif.forwardae, hif.forwardbe};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        // Cycle trace (D at c0 enters E at c1, M at c2, W at c3)
        tbl.push_back(v(1, 0, 0, 5, 1, 1, 1, 0, 1, C0, 0, 0));    // c0  lw x5
        tbl.push_back(v(1, 5, 0, 6, 1, 0, 0, 0, 1, CLU, 0, 0));   // c1  add x6,x5 -> load-use
        tbl.push_back(v(1, 5, 0, 6, 1, 0, 0, 0, 1, C0, 0, 0));    // c2  add held, bubble in E
        tbl.push_back(nop(C0, 2'b01, 2'b00));                     // c3  add in E, lw in W
        tbl.push_back(v(1, 0, 0, 3, 1, 0, 0, 0, 1, C0, 0, 0));    // c4  add x3
        tbl.push_back(v(1, 0, 3, 7, 1, 0, 0, 0, 1, C0, 0, 0));    // c5  sub rs2=x3
        tbl.push_back(v(1, 3, 0, 8, 1, 0, 0, 0, 1, C0, 0, 2));    // c6  xor rs1=x3; sub fwd M
        tbl.push_back(nop(C0, 2'b01, 2'b00));                     // c7  xor fwd W
        tbl.push_back(v(1, 1, 2, 0, 1, 0, 0, 0, 1, C0, 0, 0));    // c8  add x0
        tbl.push_back(v(1, 9, 0, 10, 1, 0, 0, 0, 1, C0, 0, 0));   // c9  sub rs2=x0
        tbl.push_back(nop(C0, 2'b00, 2'b00));                     // c10 M rd=x0 no fwd
        tbl.push_back(nop(C0, 2'b00, 2'b00));                     // c11 W rd=x0 no fwd
        tbl.push_back(v(1, 0, 0, 4, 1, 0, 0, 0, 1, C0, 0, 0));    // c12 add x4 (a)
        tbl.push_back(v(1, 0, 0, 4, 1, 0, 0, 0, 1, C0, 0, 0));    // c13 add x4 (b)
        tbl.push_back(v(1, 4, 4, 12, 1, 0, 0, 0, 1, C0, 0, 0));   // c14 or x4,x4
        tbl.push_back(nop(C0, 2'b10, 2'b10));                     // c15 M beats W
        tbl.push_back(v(1, 0, 0, 0, 1, 1, 1, 0, 1, C0, 0, 0));    // c16 lw x0
        tbl.push_back(v(1, 0, 0, 13, 1, 0, 0, 0, 1, C0, 0, 0));   // c17 use x0: no stall
        tbl.push_back(nop(C0, 2'b00, 2'b00));                     // c18
        tbl.push_back(v(1, 0, 0, 14, 1, 0, 0, 1, 1, CBR, 0, 0));  // c19 branch taken
        tbl.push_back(v(1, 0, 0, 15, 1, 0, 0, 0, 1, C0, 0, 0));   // c20 target B
        tbl.push_back(v(1, 15, 14, 16, 1, 0, 0, 0, 1, C0, 0, 0)); // c21 C, B in E
        tbl.push_back(nop(C0, 2'b10, 2'b00));                     // c22 B in M, A flushed
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 1, C0, 0, 0));    // c23 sw
        tbl.push_back(v(1, 0, 0, 17, 1, 0, 0, 0, 1, C0, 0, 0));   // c24 X
        tbl.push_back(v(1, 0, 0, 18, 1, 0, 0, 1, 0, CMW, 0, 0));  // c25 wait 1 + pcsrc
        tbl.push_back(v(1, 0, 0, 18, 1, 0, 0, 1, 0, CMW, 0, 0));  // c26 wait 2
        tbl.push_back(v(1, 0, 0, 18, 1, 0, 0, 1, 0, CMW, 0, 0));  // c27 wait 3
        tbl.push_back(v(1, 0, 0, 18, 1, 0, 0, 1, 1, CBR, 0, 0));  // c28 ready: flush now
        tbl.push_back(v(1, 17, 0, 19, 1, 0, 0, 0, 1, C0, 0, 0));  // c29 Z
        tbl.push_back(nop(C0, 2'b01, 2'b00));                     // c30 X survived freeze
        tbl.push_back(v(1, 0, 0, 20, 1, 1, 1, 0, 1, C0, 0, 0));   // c31 lw x20
        tbl.push_back(v(1, 0, 0, 22, 1, 1, 1, 0, 1, C0, 0, 0));   // c32 lw x22
        tbl.push_back(v(1, 22, 20, 23, 1, 0, 0, 0, 0, CMW, 0, 0));  // c33 wait masks lwstall
        tbl.push_back(v(1, 22, 20, 23, 1, 0, 0, 1, 1, CBOTH, 0, 0)); // c34 lwstall+pcsrc
        tbl.push_back(nop(C0, 2'b00, 2'b00));                     // c35

        // Reset entry with a live-looking D instruction
        rst_n = 1'b0;
        drive(v(1, 0, 0, 5, 1, 1, 1, 1, 1, C0, 0, 0));
        @(negedge clk); #2;
        chk("reset_pcsrc1", {21'd0, outs()}, {21'd0, CBR, 2'b00, 2'b00});
        hif.pcsrc_e = 1'b0;
        #1;
        chk("reset_idle", {21'd0, outs()}, {21'd0, C0, 2'b00, 2'b00});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(v(1, 5, 5, 0, 0, 0, 0, 0, 1, C0, 0, 0));
        #2;
        chk("release_first", {21'd0, outs()}, {21'd0, C0, 2'b00, 2'b00});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(nop(C0, 0, 0));
        end

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #2;
            chk($sformatf("vec_c%0d", i), {21'd0, outs()},
                {21'd0, tbl[i].ctrl, tbl[i].fa, tbl[i].fb});
        end

        @(negedge clk);
        drive(nop(C0, 0, 0));
`ifdef HAZARD_PERF_CNT_EN
        #2;
        chk("stall_cnt", stall_cnt, 32'd2);
        chk("flush_cnt", flush_cnt, 32'd3);
        chk("memwait_cnt", memwait_cnt, 32'd4);
`endif

        // Mid-operation reset: forwarding state must vanish immediately
        @(negedge clk);
        drive(v(1, 0, 0, 24, 1, 0, 0, 0, 1, C0, 0, 0));
        @(negedge clk);
        drive(v(1, 24, 24, 25, 1, 0, 0, 0, 1, C0, 0, 0));
        @(negedge clk);
        drive(nop(C0, 0, 0));
        #2;
        chk("pre_reset_fwd", {21'd0, outs()}, {21'd0, C0, 2'b10, 2'b10});
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset_clear", {21'd0, outs()}, {21'd0, C0, 2'b00, 2'b00});
`ifdef HAZARD_PERF_CNT_EN
        chk("mid_reset_cnt", stall_cnt | flush_cnt | memwait_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(nop(C0, 0, 0));
        @(negedge clk); #2;
        chk("post_reset_idle", {21'd0, outs()}, {21'd0, C0, 2'b00, 2'b00});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
